// File: rtl/line_buffer_pingpong_pkg.sv
// Shared VGA constants and helpers for the ping-pong line buffer.
//   VGA_LINE_PIXELS : visible pixels per line
//   VGA_COLOR_W     : bits per pixel (VgaController color width)
//   VGA_PIXEL_X_W   : width of the VgaController pixel column counter
package line_buffer_pingpong_pkg;

    localparam int unsigned VGA_LINE_PIXELS = 640;
    localparam int unsigned VGA_COLOR_W     = 3;
    localparam int unsigned VGA_PIXEL_X_W   = 10;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    // The bank that is not the given one (write bank from read bank).
    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// One line bank: single write port, single registered read port.
//   clk     : clock
//   we_i    : write enable; waddr_i / wdata_i : write address / data
//   re_i    : read enable;  raddr_i : read address
//   rdata_o : read data, valid the cycle after re_i (holds otherwise)
module line_bank_ram #(
    parameter  int unsigned DEPTH  = 640,
    parameter  int unsigned WIDTH  = 3,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Plain write-first-free array with registered read: maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_pingpong.sv
// Ping-pong line buffer between a pixel writer and the VGA controller.
// A writer fills one bank while the controller scans the other; banks are
// exchanged on lineSwap only when the write bank is already full.
//   clk, rst       : clock, synchronous active-low reset
//   wrValid/wrColor/wrReady : writer handshake and pixel data
//   lineSwap       : start-of-visible-line pulse
//   pixelX, displayActive : scan position and visible-region flag
//   color          : pixel to the controller, one cycle after pixelX
//   underrun       : sticky, a swap found the write bank not full
module line_buffer_pingpong
    import line_buffer_pingpong_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = VGA_LINE_PIXELS,
    parameter int unsigned COLOR_W     = VGA_COLOR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrValid,
    input  logic [COLOR_W-1:0]       wrColor,
    output logic                     wrReady,
    input  logic                     lineSwap,
    input  logic [VGA_PIXEL_X_W-1:0] pixelX,
    input  logic                     displayActive,
    output logic [COLOR_W-1:0]       color,
    output logic                     underrun
);

    localparam int unsigned ADDR_W = $clog2(LINE_PIXELS);

    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic              bank_full_q, bank_full_d;
    logic              wr_ready_q,  wr_ready_d;
    bank_e             rd_bank_q,   rd_bank_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              underrun_q,  underrun_d;
    logic              rd_en_q,     rd_en_d;
    bank_e             rd_src_q,    rd_src_d;

    logic              wr_fire_c;
    logic              wr_last_c;
    bank_e             wr_bank_c;
    logic [COLOR_W-1:0] bank_rdata [2];

    assign wr_fire_c = wrValid && wr_ready_q;
    assign wr_last_c = (wr_ptr_q == ADDR_W'(LINE_PIXELS - 1));
    assign wr_bank_c = other_bank(rd_bank_q);

    // Next-state: write pointer/fill tracking and swap decision on registered full.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        bank_full_d = bank_full_q;
        wr_ready_d  = wr_ready_q;
        rd_bank_d   = rd_bank_q;
        rd_valid_d  = rd_valid_q;
        underrun_d  = underrun_q;
        rd_en_d     = displayActive && rd_valid_q && (32'(pixelX) < LINE_PIXELS);
        rd_src_d    = rd_bank_q;

        if (wr_fire_c) begin
            if (wr_last_c) begin
                wr_ptr_d    = '0;
                bank_full_d = 1'b1;
                wr_ready_d  = 1'b0;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end

        // A full bank blocks writes, so a successful swap never races a write.
        if (lineSwap) begin
            if (bank_full_q) begin
                rd_bank_d   = wr_bank_c;
                bank_full_d = 1'b0;
                wr_ready_d  = 1'b1;
                rd_valid_d  = 1'b1;
            end else begin
                underrun_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; bank memory is not cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            bank_full_q <= 1'b0;
            wr_ready_q  <= 1'b1;
            rd_bank_q   <= BANK_0;
            rd_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_src_q    <= BANK_0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            bank_full_q <= bank_full_d;
            wr_ready_q  <= wr_ready_d;
            rd_bank_q   <= rd_bank_d;
            rd_valid_q  <= rd_valid_d;
            underrun_q  <= underrun_d;
            rd_en_q     <= rd_en_d;
            rd_src_q    <= rd_src_d;
        end
    end

    // Each bank is written only as the write bank and read only as the read bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank_ram #(
            .DEPTH (LINE_PIXELS),
            .WIDTH (COLOR_W)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_fire_c && (wr_bank_c == bank_e'(b))),
            .waddr_i (wr_ptr_q),
            .wdata_i (wrColor),
            .re_i    (rd_en_d && (rd_bank_q == bank_e'(b))),
            .raddr_i (ADDR_W'(pixelX)),
            .rdata_o (bank_rdata[b])
        );
    end

    // RAM output is already registered; the registered enable blanks it.
    assign color    = rd_en_q ? bank_rdata[rd_src_q] : '0;
    assign wrReady  = wr_ready_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_line_buffer_pingpong.sv
module tb_line_buffer_pingpong;

    localparam int NPIX = 640;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrValid;
    logic [2:0] wrColor;
    logic       wrReady;
    logic       lineSwap;
    logic [9:0] pixelX;
    logic       displayActive;
    logic [2:0] color;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    // Reference model: two line arrays, which one is displayed, fill count.
    logic [2:0] m_mem [2][NPIX];
    int         m_ptr   = 0;
    bit         m_full  = 0;
    int         m_rd    = 0;
    bit         m_valid = 0;
    bit         m_under = 0;
    logic [2:0] m_color = '0;

    logic [2:0] first_px;

    always #10 clk = ~clk;

    line_buffer_pingpong dut (
        .clk           (clk),
        .rst           (rst),
        .wrValid       (wrValid),
        .wrColor       (wrColor),
        .wrReady       (wrReady),
        .lineSwap      (lineSwap),
        .pixelX        (pixelX),
        .displayActive (displayActive),
        .color         (color),
        .underrun      (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] c,
                        input logic sw, input logic da, input logic [9:0] px);
        int  wb;
        bit  acc;
        rst = r; wrValid = v; wrColor = c; lineSwap = sw;
        displayActive = da; pixelX = px;
        @(posedge clk);
        if (!r) begin
            m_ptr = 0; m_full = 0; m_rd = 0; m_valid = 0; m_under = 0; m_color = '0;
        end else begin
            if (da && m_valid && int'(px) < NPIX) m_color = m_mem[m_rd][int'(px)];
            else                                   m_color = '0;
            acc = v && !m_full;
            wb  = 1 - m_rd;
            if (sw) begin
                if (m_full) begin
                    m_rd = wb; m_full = 0; m_valid = 1;
                end else begin
                    m_under = 1;
                end
            end
            if (acc) begin
                m_mem[wb][m_ptr] = c;
                m_ptr++;
                if (m_ptr == NPIX) begin
                    m_ptr = 0; m_full = 1;
                end
            end
        end
        #1;
        chk("color",    32'(color),    32'(m_color));
        chk("wrReady",  32'(wrReady),  32'(!m_full));
        chk("underrun", 32'(underrun), 32'(m_under));
    endtask

    // Random scan position/visibility, reset released.
    task automatic step_r(input logic v, input logic [2:0] c, input logic sw);
        logic       da;
        logic [9:0] px;
        da = ($urandom_range(0, 3) != 0);
        px = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(640, 1023))
                                         : 10'($urandom_range(0, 639));
        step(1'b1, v, c, sw, da, px);
    endtask

    initial begin
        // Reset held two cycles with a visible request at column 5.
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 10'd5);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 10'd5);
        chk("rst_color",    32'(color),    32'd0);
        chk("rst_wrReady",  32'(wrReady),  32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd5);
        chk("novalid_color", 32'(color), 32'd0);

        // Fill one line with i mod 8, then swap.
        for (int i = 0; i < NPIX; i++) step_r(1'b1, 3'(i % 8), 1'b0);
        chk("full_wrReady", 32'(wrReady), 32'd0);
        step_r(1'b1, 3'd7, 1'b0);
        step_r(1'b0, 3'd0, 1'b1);
        chk("swap_wrReady", 32'(wrReady), 32'd1);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd9);
        chk("px9_color", 32'(color), 32'd1);

        // Final write coinciding with lineSwap: underrun, no swap.
        for (int n = 0; n < 5000 && m_ptr != NPIX - 1; n++)
            step_r(1'($urandom_range(0, 1)), 3'($urandom), 1'b0);
        chk("coin_ptr", 32'(m_ptr), 32'(NPIX - 1));
        step_r(1'b1, 3'($urandom), 1'b1);
        chk("coin_underrun", 32'(underrun), 32'd1);
        chk("coin_wrReady",  32'(wrReady),  32'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd9);
        chk("coin_noswap_color", 32'(color), 32'd1);
        step_r(1'b0, 3'd0, 1'b1);
        chk("coin_swap_wrReady", 32'(wrReady), 32'd1);
        for (int p = 0; p < NPIX; p += 37) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'(p));
        chk("coin_sticky", 32'(underrun), 32'd1);

        // Reset mid-fill: partial line abandoned, fresh line starts at address 0.
        for (int i = 0; i < 200; i++) step_r(1'b1, 3'($urandom), 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 10'd0);
        chk("midrst_underrun", 32'(underrun), 32'd0);
        first_px = 3'($urandom);
        step_r(1'b1, first_px, 1'b0);
        for (int i = 1; i < NPIX; i++) step_r(1'b1, 3'($urandom), 1'b0);
        step_r(1'b0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd0);
        chk("midrst_px0", 32'(color), 32'(first_px));

        // Underrun on a partial line: previous line repeats, fill resumes at 300.
        for (int i = 0; i < 300; i++) step_r(1'b1, 3'($urandom), 1'b0);
        step_r(1'b0, 3'd0, 1'b1);
        chk("under_flag", 32'(underrun), 32'd1);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd0);
        chk("under_repeat_px0", 32'(color), 32'(first_px));
        for (int i = 0; i < NPIX - 300; i++) step_r(1'b1, 3'($urandom), 1'b0);
        chk("under_resume_full", 32'(wrReady), 32'd0);
        step_r(1'b0, 3'd0, 1'b1);
        for (int p = 0; p < NPIX; p++) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'(p));

        // Bounds and blanking.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd640);
        chk("bound_640", 32'(color), 32'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd1023);
        chk("bound_1023", 32'(color), 32'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 10'd3);
        chk("blank", 32'(color), 32'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 10'd639);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
